// File: rtl/vx_gbar_unit.sv
// Cluster-level global barrier responder: records per-barrier core arrivals and
// pulses a release when the last core arrives. Protocol checks build under GBAR_CHECK_EN.
module vx_gbar_unit #(
  parameter  int NUM_BARRIERS = 4,
  parameter  int NUM_CORES    = 4,
  localparam int BAR_ID_W     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int CORE_ID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [BAR_ID_W-1:0]  req_id,
  input  logic [CORE_ID_W-1:0] req_size_m1,
  input  logic [CORE_ID_W-1:0] req_core_id,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [BAR_ID_W-1:0]  rsp_id,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = CORE_ID_W + 1;

  // A barrier is gathering exactly when its mask is nonzero.
  logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
  logic [CORE_ID_W-1:0] size_q [NUM_BARRIERS];
  logic                 ready_q;
  logic                 rsp_valid_q;
  logic [BAR_ID_W-1:0]  rsp_id_q;

  logic                 id_ok;
  logic                 accept;
  logic [NUM_CORES-1:0] cur_mask;
  logic [NUM_CORES-1:0] core_bit;
  logic [NUM_CORES-1:0] mask_next;
  logic                 first;
  logic [CORE_ID_W-1:0] size_eff;
  logic [CNT_W-1:0]     pop;
  logic                 fire;
  logic                 any_mask;

  assign id_ok  = 32'(req_id) < NUM_BARRIERS;
  assign accept = req_valid && ready_q && id_ok;

  always_comb begin
    cur_mask  = mask_q[req_id];
    core_bit  = NUM_CORES'(1) << req_core_id;
    mask_next = cur_mask | core_bit;
    first     = (cur_mask == '0);
    size_eff  = first ? req_size_m1 : size_q[req_id];
    pop       = '0;
    for (int i = 0; i < NUM_CORES; i++) pop = pop + CNT_W'(mask_next[i]);
    fire      = accept && (pop == (CNT_W'(size_eff) + CNT_W'(1)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
        size_q[b] <= '0;
      end
    end else begin
      ready_q     <= 1'b1;
      rsp_valid_q <= fire;
      if (fire) rsp_id_q <= req_id;
      if (accept) begin
        mask_q[req_id] <= fire ? '0 : mask_next;
        if (first) size_q[req_id] <= req_size_m1;
      end
    end
  end

  always_comb begin
    any_mask = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) any_mask = any_mask | (|mask_q[b]);
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = any_mask | rsp_valid_q;

`ifdef GBAR_CHECK_EN
  logic dup;
  logic size_mis;
  logic core_oob;
  logic err_q;

  // Duplicates leave the mask unchanged naturally, since the OR is a no-op.
  assign dup      = |(cur_mask & core_bit);
  assign size_mis = !first && (req_size_m1 != size_q[req_id]);
  assign core_oob = req_core_id > size_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (accept && (dup || size_mis || core_oob)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Scoreboard bench for vx_gbar_unit: directed arrivals push expected releases,
// a negedge monitor pops and checks id and cycle of every rsp_valid pulse.
module tb_vx_gbar_unit;

`ifdef GBAR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_id;
  logic [1:0] req_size_m1;
  logic [1:0] req_core_id;
  logic       req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       busy;
  logic       err;

  vx_gbar_unit #(.NUM_BARRIERS(4), .NUM_CORES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_size_m1(req_size_m1),
    .req_core_id(req_core_id),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    int         cyc;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One arrival; if it should complete the barrier, queue the pulse for the next cycle.
  task automatic arrive(input logic [1:0] id, input logic [1:0] sz,
                        input logic [1:0] core, input bit rel);
    exp_t e;
    @(negedge clk);
    req_valid   = 1'b1;
    req_id      = id;
    req_size_m1 = sz;
    req_core_id = core;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (rel) begin
      e.cyc = cyc;
      e.id  = id;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest expected release, in the expected cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d at cycle %0d, expected no pulse", rsp_id, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", int'(rsp_id), int'(e.id));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_id      = '0;
    req_size_m1 = '0;
    req_core_id = '0;

    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("ready_before_edge", int'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", int'(req_ready), 1);

    // Basic four-core release on barrier 1.
    arrive(2'd1, 2'd3, 2'd0, 1'b0);
    chk("busy_gather", int'(busy), 1);
    arrive(2'd1, 2'd3, 2'd1, 1'b0);
    arrive(2'd1, 2'd3, 2'd2, 1'b0);
    arrive(2'd1, 2'd3, 2'd3, 1'b1);
    @(negedge clk);
    chk("busy_during_rsp", int'(busy), 1);
    @(negedge clk);
    chk("busy_after_rsp", int'(busy), 0);
    chk("err_after_basic", int'(err), 0);

    // Interleaved barriers 0 and 2; core 2/3 on size 1 trips the range check when enabled.
    arrive(2'd0, 2'd1, 2'd0, 1'b0);
    arrive(2'd2, 2'd1, 2'd2, 1'b0);
    arrive(2'd0, 2'd1, 2'd1, 1'b1);
    arrive(2'd2, 2'd1, 2'd3, 1'b1);
    idle(2);
    chk("err_after_interleave", int'(err), int'(CHK));

    // Immediate release, then back-to-back releases on the same barrier.
    arrive(2'd3, 2'd0, 2'd2, 1'b1);
    idle(2);
    arrive(2'd3, 2'd0, 2'd0, 1'b1);
    arrive(2'd3, 2'd0, 2'd0, 1'b1);
    idle(2);
    chk("busy_after_imm", int'(busy), 0);

    // Epoch reuse: a new arrival right after release starts a fresh mask.
    arrive(2'd0, 2'd2, 2'd0, 1'b0);
    arrive(2'd0, 2'd2, 2'd1, 1'b0);
    arrive(2'd0, 2'd2, 2'd2, 1'b1);
    arrive(2'd0, 2'd1, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("busy_new_epoch", int'(busy), 1);
    arrive(2'd0, 2'd1, 2'd1, 1'b1);
    idle(2);
    chk("busy_epoch_done", int'(busy), 0);

    // Duplicate arrival must not count toward the release.
    arrive(2'd0, 2'd3, 2'd0, 1'b0);
    arrive(2'd0, 2'd3, 2'd1, 1'b0);
    arrive(2'd0, 2'd3, 2'd1, 1'b0);
    arrive(2'd0, 2'd3, 2'd2, 1'b0);
    idle(1);
    chk("err_after_dup", int'(err), int'(CHK));
    chk("busy_after_dup", int'(busy), 1);
    arrive(2'd0, 2'd3, 2'd3, 1'b1);
    idle(2);

    // Asynchronous reset mid-gather, off the clock edge.
    arrive(2'd1, 2'd3, 2'd0, 1'b0);
    arrive(2'd1, 2'd3, 2'd1, 1'b0);
    arrive(2'd1, 2'd3, 2'd2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_ready", int'(req_ready), 0);
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    arrive(2'd1, 2'd3, 2'd3, 1'b0);
    arrive(2'd1, 2'd3, 2'd0, 1'b0);
    arrive(2'd1, 2'd3, 2'd1, 1'b0);
    idle(1);
    chk("busy_post_reset", int'(busy), 1);
    arrive(2'd1, 2'd3, 2'd2, 1'b1);
    idle(3);
    chk("busy_final", int'(busy), 0);
    chk("pending_rsp", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
